stg4mo: RTL and testbench

Memory-operation stage of the five-stage core, directly downstream of the execute stage. It takes the execute latch and passes ALU results through with one cycle of latency. For load/store opcodes it runs a request/acknowledge transaction on the data-memory port and stalls upstream until the transaction completes. Its output latch is the "mamo" register: it feeds back into execute's forwarding path and forward into writeback.

---
 rtl/stg4mo_pkg.sv | 37 +++
 rtl/stg4mo_waitcnt.sv | 43 ++++
 rtl/stg4mo.sv | 136 +++++++++++++
 tb/tb_stg4mo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stg4mo_pkg.sv
// Shared widths, opcodes, FSM encoding and the mamo latch payload for the
// memory-operation stage.
package stg4mo_pkg;

    localparam int unsigned SIZE_ADDR   = 24;
    localparam int unsigned SIZE_DATA   = 24;
    localparam int unsigned SIZE_OPC    = 6;
    localparam int unsigned SIZE_TGT_GP = 4;
    localparam int unsigned SIZE_TGT_SR = 2;
    localparam int unsigned HBIT_ADDR   = SIZE_ADDR - 1;

    localparam logic [SIZE_OPC-1:0] OPC_NOP   = SIZE_OPC'(0);
    localparam logic [SIZE_OPC-1:0] OPC_A_ADD = SIZE_OPC'(1);
    localparam logic [SIZE_OPC-1:0] OPC_M_LD  = SIZE_OPC'(32);
    localparam logic [SIZE_OPC-1:0] OPC_M_ST  = SIZE_OPC'(33);

    typedef enum logic {
        MO_IDLE = 1'b0,
        MO_BUSY = 1'b1
    } mo_state_e;

    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic                   tgt_gp_we;
        logic [SIZE_TGT_SR-1:0] tgt_sr;
        logic                   tgt_sr_we;
        logic [SIZE_DATA-1:0]   result;
    } mamo_t;

    function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_M_LD) || (opc == OPC_M_ST);
    endfunction

endpackage

// File: rtl/stg4mo_waitcnt.sv
// Wait counter for the memory stage: synchronous clear, increment, and a
// registered terminal flag that is high while the count equals P_WAIT_MAX-1.
module mo_waitcnt
    import stg4mo_pkg::*;
#(
    parameter int unsigned P_WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int unsigned W = $clog2(P_WAIT_MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         term_q, term_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
        term_d = (cnt_d == W'(P_WAIT_MAX - 1));
    end

    // Terminal flag tracks the next count so it is valid in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            term_q <= (P_WAIT_MAX == 1);
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign term_o = term_q;

endmodule

// File: rtl/stg4mo.sv
// Memory-operation stage: passes ALU results through the mamo latch and runs
// the req/ack data-memory transaction for loads and stores, stalling upstream.
module stg4mo
    import stg4mo_pkg::*;
#(
    parameter int unsigned P_WAIT_MAX = 15
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst_n,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    input  logic [SIZE_DATA-1:0]   iw_instr,
    output logic [SIZE_DATA-1:0]   ow_instr,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    output logic [SIZE_OPC-1:0]    ow_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    input  logic                   iw_tgt_gp_we,
    output logic                   ow_tgt_gp_we,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    input  logic                   iw_tgt_sr_we,
    output logic                   ow_tgt_sr_we,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [SIZE_DATA-1:0]   iw_st_data,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic                   ow_stall,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic [SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
    output logic                   ow_mem_err
);

    mo_state_e state_q, state_d;
    mamo_t     lat_q, lat_d;
    logic      err_q, err_d;
    logic      is_mem, ack, term, cnt_clr, cnt_inc, stall;

    assign is_mem = is_mem_op(iw_opc);
    assign ack    = iw_mem_ack & is_mem;

    mo_waitcnt #(.P_WAIT_MAX(P_WAIT_MAX)) u_waitcnt (
        .clk_i  (iw_clk),
        .rst_n_i(iw_rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_o (term)
    );

    always_comb begin
        state_d         = state_q;
        stall           = 1'b0;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        err_d           = 1'b0;
        lat_d.pc        = iw_pc;
        lat_d.instr     = iw_instr;
        lat_d.opc       = iw_opc;
        lat_d.tgt_gp    = iw_tgt_gp;
        lat_d.tgt_gp_we = iw_tgt_gp_we;
        lat_d.tgt_sr    = iw_tgt_sr;
        lat_d.tgt_sr_we = iw_tgt_sr_we;
        lat_d.result    = iw_result;

        case (state_q)
            MO_IDLE: begin
                cnt_clr = 1'b1;
                if (is_mem && !ack) begin
                    stall   = 1'b1;
                    state_d = MO_BUSY;
                end
            end
            MO_BUSY: begin
                if (!is_mem || ack) begin
                    state_d = MO_IDLE;
                end else if (term) begin
                    err_d   = 1'b1;
                    state_d = MO_IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
        endcase

        // Any memory op without ack (stall or abort) latches a bubble.
        if (is_mem) begin
            if (ack) begin
                if (iw_opc == OPC_M_ST) begin
                    lat_d.result    = SIZE_DATA'(iw_result[HBIT_ADDR:0]);
                    lat_d.tgt_gp_we = 1'b0;
                    lat_d.tgt_sr_we = 1'b0;
                end else begin
                    lat_d.result = iw_mem_rdata;
                end
            end else begin
                lat_d.opc       = OPC_NOP;
                lat_d.tgt_gp_we = 1'b0;
                lat_d.tgt_sr_we = 1'b0;
                lat_d.result    = '0;
            end
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q <= MO_IDLE;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    assign ow_pc        = lat_q.pc;
    assign ow_instr     = lat_q.instr;
    assign ow_opc       = lat_q.opc;
    assign ow_tgt_gp    = lat_q.tgt_gp;
    assign ow_tgt_gp_we = lat_q.tgt_gp_we;
    assign ow_tgt_sr    = lat_q.tgt_sr;
    assign ow_tgt_sr_we = lat_q.tgt_sr_we;
    assign ow_result    = lat_q.result;
    assign ow_mem_err   = err_q;

    assign ow_stall     = stall;
    assign ow_mem_req   = is_mem;
    assign ow_mem_we    = (iw_opc == OPC_M_ST);
    assign ow_mem_addr  = iw_result[HBIT_ADDR:0];
    assign ow_mem_wdata = iw_st_data;

endmodule

// File: tb/tb_stg4mo.sv
// Directed bench for stg4mo: expected mamo contents are queued when a cycle's
// stimulus is driven and popped after the following rising edge.
`timescale 1ns/1ps
module tb_stg4mo;
    import stg4mo_pkg::*;

    localparam int unsigned WAIT_MAX = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [SIZE_ADDR-1:0]   pc_i, pc_o;
    logic [SIZE_DATA-1:0]   instr_i, instr_o;
    logic [SIZE_OPC-1:0]    opc_i, opc_o;
    logic [SIZE_TGT_GP-1:0] tgt_gp_i, tgt_gp_o;
    logic                   gp_we_i, gp_we_o;
    logic [SIZE_TGT_SR-1:0] tgt_sr_i, tgt_sr_o;
    logic                   sr_we_i, sr_we_o;
    logic [SIZE_DATA-1:0]   result_i, st_data_i, result_o;
    logic                   stall, mem_req, mem_we, mem_ack, mem_err;
    logic [SIZE_ADDR-1:0]   mem_addr;
    logic [SIZE_DATA-1:0]   mem_wdata, mem_rdata;

    typedef struct {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic                   gp_we;
        logic                   sr_we;
        logic [SIZE_DATA-1:0]   result;
        logic                   err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stg4mo #(.P_WAIT_MAX(WAIT_MAX)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n),
        .iw_pc(pc_i), .ow_pc(pc_o),
        .iw_instr(instr_i), .ow_instr(instr_o),
        .iw_opc(opc_i), .ow_opc(opc_o),
        .iw_tgt_gp(tgt_gp_i), .ow_tgt_gp(tgt_gp_o),
        .iw_tgt_gp_we(gp_we_i), .ow_tgt_gp_we(gp_we_o),
        .iw_tgt_sr(tgt_sr_i), .ow_tgt_sr(tgt_sr_o),
        .iw_tgt_sr_we(sr_we_i), .ow_tgt_sr_we(sr_we_o),
        .iw_result(result_i), .iw_st_data(st_data_i), .ow_result(result_o),
        .ow_stall(stall), .ow_mem_req(mem_req), .ow_mem_we(mem_we),
        .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
        .iw_mem_ack(mem_ack), .iw_mem_rdata(mem_rdata), .ow_mem_err(mem_err)
    );

    function automatic logic [SIZE_DATA-1:0] instr_of(input logic [SIZE_ADDR-1:0] pc);
        return SIZE_DATA'(pc) ^ SIZE_DATA'(24'hA5A5A5);
    endfunction

    function automatic exp_t mk(input logic [SIZE_ADDR-1:0] pc, input logic [SIZE_OPC-1:0] opc,
                                input logic [SIZE_TGT_GP-1:0] tgt, input logic gp_we,
                                input logic [SIZE_DATA-1:0] result, input logic err);
        exp_t e;
        e.pc = pc; e.opc = opc; e.tgt_gp = tgt; e.gp_we = gp_we;
        e.sr_we = 1'b0; e.result = result; e.err = err;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [SIZE_ADDR-1:0] pc, input logic [SIZE_OPC-1:0] opc,
                          input logic [SIZE_DATA-1:0] res, input logic [SIZE_DATA-1:0] sd,
                          input logic [SIZE_TGT_GP-1:0] tgt, input logic gp_we,
                          input logic ack, input logic [SIZE_DATA-1:0] rdata);
        pc_i = pc; instr_i = instr_of(pc); opc_i = opc; result_i = res; st_data_i = sd;
        tgt_gp_i = tgt; gp_we_i = gp_we; tgt_sr_i = 2'd1; sr_we_i = 1'b0;
        mem_ack = ack; mem_rdata = rdata;
    endtask

    // Check combinational outputs, queue the expected latch, clock, then compare.
    task automatic cyc(input string tag, input exp_t e, input logic e_stall, input logic e_req);
        exp_t got;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".req"}, 32'(mem_req), 32'(e_req));
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".opc"}, 32'(opc_o), 32'(got.opc));
        chk({tag, ".result"}, 32'(result_o), 32'(got.result));
        chk({tag, ".gp_we"}, 32'(gp_we_o), 32'(got.gp_we));
        chk({tag, ".sr_we"}, 32'(sr_we_o), 32'(got.sr_we));
        chk({tag, ".pc"}, 32'(pc_o), 32'(got.pc));
        chk({tag, ".instr"}, 32'(instr_o), 32'(instr_of(got.pc)));
        chk({tag, ".err"}, 32'(mem_err), 32'(got.err));
        if (got.opc != OPC_NOP) chk({tag, ".tgt_gp"}, 32'(tgt_gp_o), 32'(got.tgt_gp));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pc"}, 32'(pc_o), 32'd0);
        chk({tag, ".instr"}, 32'(instr_o), 32'd0);
        chk({tag, ".opc"}, 32'(opc_o), 32'd0);
        chk({tag, ".tgt_gp"}, 32'(tgt_gp_o), 32'd0);
        chk({tag, ".gp_we"}, 32'(gp_we_o), 32'd0);
        chk({tag, ".tgt_sr"}, 32'(tgt_sr_o), 32'd0);
        chk({tag, ".sr_we"}, 32'(sr_we_o), 32'd0);
        chk({tag, ".result"}, 32'(result_o), 32'd0);
        chk({tag, ".err"}, 32'(mem_err), 32'd0);
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(24'h0, OPC_NOP, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0, 24'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // ALU pass-through
        set_in(24'h100, OPC_A_ADD, 24'h000123, 24'h0, 4'd3, 1'b1, 1'b0, 24'h0);
        cyc("add", mk(24'h100, OPC_A_ADD, 4'd3, 1'b1, 24'h000123, 1'b0), 1'b0, 1'b0);

        // Zero-wait load
        set_in(24'h104, OPC_M_LD, 24'h000040, 24'h0, 4'd5, 1'b1, 1'b1, 24'hABCDEF);
        #1;
        chk("ld0.addr", 32'(mem_addr), 32'h40);
        chk("ld0.we", 32'(mem_we), 32'd0);
        cyc("ld0", mk(24'h104, OPC_M_LD, 4'd5, 1'b1, 24'hABCDEF, 1'b0), 1'b0, 1'b1);

        // Store acknowledged after three wait cycles
        set_in(24'h108, OPC_M_ST, 24'h000010, 24'h000055, 4'd2, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st3.wdata", 32'(mem_wdata), 32'h55);
            chk("st3.we", 32'(mem_we), 32'd1);
            cyc("st3.wait", mk(24'h108, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b1, 1'b1);
        end
        mem_ack = 1'b1;
        cyc("st3.done", mk(24'h108, OPC_M_ST, 4'd2, 1'b0, 24'h000010, 1'b0), 1'b0, 1'b1);

        // Load never acknowledged: abort after WAIT_MAX stalled cycles
        set_in(24'h10C, OPC_M_LD, 24'h000044, 24'h0, 4'd4, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < int'(WAIT_MAX); i++)
            cyc("abort.wait", mk(24'h10C, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b1, 1'b1);
        cyc("abort.cyc", mk(24'h10C, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b1), 1'b0, 1'b1);
        set_in(24'h110, OPC_NOP, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0, 24'h0);
        cyc("abort.after", mk(24'h110, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b0, 1'b0);

        // Reset asserted while BUSY, stray ack after release
        set_in(24'h114, OPC_M_LD, 24'h000048, 24'h0, 4'd6, 1'b1, 1'b0, 24'h0);
        cyc("rstbusy.enter", mk(24'h114, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b1, 1'b1);
        rst_n = 1'b0;
        set_in(24'h0, OPC_NOP, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0, 24'h0);
        #1;
        chk_zero("rstbusy.rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(24'h118, OPC_NOP, 24'h0, 24'h0, 4'd6, 1'b0, 1'b1, 24'h00DEAD);
        cyc("rstbusy.ack", mk(24'h118, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b0, 1'b0);

        // Back-to-back loads, one wait cycle each
        set_in(24'h120, OPC_M_LD, 24'h000050, 24'h0, 4'd6, 1'b1, 1'b0, 24'h0);
        cyc("ldA.wait", mk(24'h120, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b1, 1'b1);
        set_in(24'h120, OPC_M_LD, 24'h000050, 24'h0, 4'd6, 1'b1, 1'b1, 24'h111111);
        cyc("ldA.done", mk(24'h120, OPC_M_LD, 4'd6, 1'b1, 24'h111111, 1'b0), 1'b0, 1'b1);
        set_in(24'h124, OPC_M_LD, 24'h000054, 24'h0, 4'd7, 1'b1, 1'b0, 24'h0);
        cyc("ldB.wait", mk(24'h124, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b1, 1'b1);
        set_in(24'h124, OPC_M_LD, 24'h000054, 24'h0, 4'd7, 1'b1, 1'b1, 24'h222222);
        cyc("ldB.done", mk(24'h124, OPC_M_LD, 4'd7, 1'b1, 24'h222222, 1'b0), 1'b0, 1'b1);
        set_in(24'h128, OPC_NOP, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0, 24'h0);
        cyc("tail", mk(24'h128, OPC_NOP, 4'd0, 1'b0, 24'h0, 1'b0), 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
